// File: rtl/param_ram_pkg.sv
// -----------------------------------------------------------------------------
// param_ram_pkg
// Shared definitions for the param_ram slice.
//   - state_t      : controller state (ST_CLEAR while the array is being
//                    zeroed, ST_IDLE while normal accesses are served)
//   - DEF_DATA_W   : default word width in bits
//   - DEF_ADDR_W   : default address width in bits
//   - depth_of()   : number of words addressed by an address of a given width
// -----------------------------------------------------------------------------
package param_ram_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // The array always spans the full address space, so depth follows the
    // address width and is never configured on its own.
    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage : param_ram_pkg

// File: rtl/param_ram_ram_core.sv
// -----------------------------------------------------------------------------
// ram_core
// Storage array with one write port and one registered read port.
//   clk       : clock, all state changes on its rising edge
//   rst       : synchronous active-high reset of the read port only; the
//               array contents are never touched by reset
//   wr_en     : write wr_data into mem[wr_addr] at this edge
//   wr_addr   : write word address
//   wr_data   : write data
//   rd_en     : capture mem[rd_addr] into rd_data at this edge
//   rd_addr   : read word address
//   rd_data   : registered read data (holds while rd_en is low)
//   rd_valid  : rd_data was captured at the most recent edge
//   mem_view  : combinational view of every word of the array
// -----------------------------------------------------------------------------
module ram_core
    import param_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [ADDR_W-1:0]                     wr_addr,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic                                  rd_en,
    input  logic [ADDR_W-1:0]                     rd_addr,
    output logic [DATA_W-1:0]                     rd_data,
    output logic                                  rd_valid,
    output logic [(2**ADDR_W)-1:0][DATA_W-1:0]    mem_view
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0][DATA_W-1:0] mem_r;
    logic [DATA_W-1:0]            rd_data_r;
    logic                         rd_valid_r;

    // Array write port; reset deliberately leaves the contents alone so that
    // zeroing is always done by the controller's clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r <= mem_r;
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Registered read port. Both ports sample the array before this edge's
    // write lands, so a same-address read/write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_en) begin
            rd_data_r  <= mem_r[rd_addr];
            rd_valid_r <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign mem_view = mem_r;

endmodule : ram_core

// File: rtl/param_ram.sv
// -----------------------------------------------------------------------------
// param_ram
// Parameterised single-port RAM with a self-clearing sequence.
// After reset (and on every clear request) the controller walks the whole
// array writing zeros, one word per cycle, and blocks all accesses meanwhile.
//   clk          : clock
//   rst          : synchronous active-high reset; restarts the clear sequence
//   address      : read/write word address
//   write_enable : write sw into mem[address] at this edge (idle only)
//   sw           : write data
//   clear_req    : one-cycle request to zero the whole array (idle only;
//                  takes priority over a simultaneous write)
//   led          : registered read data, one edge after the address
//   read_valid   : led was refreshed at the most recent edge
//   busy         : clear sequence running; reads and writes are ignored
//   ram_test     : combinational debug view of the whole array
// -----------------------------------------------------------------------------
module param_ram
    import param_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDR_W-1:0]                     address,
    input  logic                                  write_enable,
    input  logic [DATA_W-1:0]                     sw,
    input  logic                                  clear_req,
    output logic [DATA_W-1:0]                     led,
    output logic                                  read_valid,
    output logic                                  busy,
    output logic [(2**ADDR_W)-1:0][DATA_W-1:0]    ram_test
);

    // Pointer to the final word; an all-ones address equals DEPTH-1.
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1'b1);

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_ptr_r;

    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                rd_en_s;

    // Clear/idle controller: reset and clear requests both restart the walk
    // from word 0; the last zeroed word hands control back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r   <= ST_IDLE;
                        clr_ptr_r <= clr_ptr_r;
                    end else begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= clr_ptr_r + PTR_STEP;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end else begin
                        state_r   <= ST_IDLE;
                        clr_ptr_r <= clr_ptr_r;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Array port steering: the clear walk owns the write port while busy;
    // in idle a clear request suppresses both the user write and the read so
    // that read_valid never rises while the array is being cleared.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = address;
        wr_data_s = sw;
        rd_en_s   = 1'b0;
        if (rst) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_ptr_r;
                    wr_data_s = {DATA_W{1'b0}};
                    rd_en_s   = 1'b0;
                end
                ST_IDLE: begin
                    wr_en_s = write_enable & ~clear_req;
                    rd_en_s = ~clear_req;
                end
                default: begin
                    wr_en_s = 1'b0;
                    rd_en_s = 1'b0;
                end
            endcase
        end
    end

    ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_core (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_addr  (wr_addr_s),
        .wr_data  (wr_data_s),
        .rd_en    (rd_en_s),
        .rd_addr  (address),
        .rd_data  (led),
        .rd_valid (read_valid),
        .mem_view (ram_test)
    );

    // busy is a direct decode of the state register.
    assign busy = (state_r == ST_CLEAR);

endmodule : param_ram

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 3, word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 2, address width in bits (>=1); DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port address  input  ADDR_W  read/write word address.
REQ-006 SHALL have port write_enable  input  1  write sw to mem[address] this cycle.
REQ-007 SHALL have port sw  input  DATA_W  write data.
REQ-008 SHALL have port clear_req  input  1  single-cycle request to zero the whole array.
REQ-009 SHALL have port led  output  DATA_W  registered read data.
REQ-010 SHALL have port read_valid  output  1  led holds data for the address sampled one cycle earlier.
REQ-011 SHALL have port busy  output  1  clear sequence in progress; accesses ignored.
REQ-012 SHALL have port ram_test  output  DEPTH x DATA_W packed, [DEPTH-1:0][DATA_W-1:0]  combinational debug view of the whole array.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and IDLE; busy = (state == CLEAR).
REQ-014 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr]; if clr_ptr == DEPTH-1, go to IDLE, else clr_ptr += 1.
REQ-015 CLEAR SHALL last exactly DEPTH cycles after entry; busy deasserts on the cycle after the last word is zeroed.
REQ-016 In IDLE, clear_req = 1 SHALL set clr_ptr = 0 and enter CLEAR on the next edge.
REQ-017 clear_req SHALL be ignored while busy; clearing does not restart.
REQ-018 In IDLE, write_enable = 1 and clear_req = 0 SHALL write sw to mem[address] at that edge.
REQ-019 In IDLE, clear_req and write_enable asserted together SHALL drop the write; clear wins.
REQ-020 Writes SHALL be ignored while busy.
REQ-021 Read latency SHALL be 1 cycle: in IDLE, led <= mem[address] and read_valid <= 1 at each edge.
REQ-022 Read and write to the same address in the same cycle SHALL be read-first: led gets the old word.
REQ-023 While busy, led SHALL hold its last value and read_valid SHALL be 0.
REQ-024 An address change SHALL be reflected on led exactly one edge later; addresses wrap only by ADDR_W truncation.
REQ-025 ram_test[i] SHALL equal mem[i] for all i, with no added latency.

Reset
REQ-026 With rst = 1 at a posedge: state = CLEAR, clr_ptr = 0, led = 0, read_valid = 0, busy = 1; mem is not written that cycle.
REQ-027 Reset held for N cycles SHALL keep those values; clearing starts on the first edge with rst = 0.
REQ-028 Reset during CLEAR or IDLE SHALL restart the clear from word 0 and discard any same-cycle write.
REQ-029 After reset release, busy SHALL stay 1 for exactly DEPTH cycles; every mem word is then 0.

Structure
REQ-030 Shared package param_ram_pkg SHALL hold the state typedef (ST_CLEAR, ST_IDLE) and the default width constants.
REQ-031 The storage array and registered read port SHALL be one sub-module, ram_core. The FSM and clear pointer SHALL stay in param_ram.
REQ-032 DEPTH SHALL be derived from ADDR_W, not passed as a separate parameter.

Verification (DATA_W = 3, ADDR_W = 2 unless stated)
REQ-033 Reset 2 cycles, then release -> busy = 1 for 4 cycles, then 0; ram_test = all 0; read_valid = 0 until busy falls.
REQ-034 Write 001, 010, 011, 100 to addresses 0..3, then read 0..3 -> led = 001, 010, 011, 100, each one cycle after its address; read_valid = 1.
REQ-035 Same-cycle read and write of 101 to address 2 holding 011 -> led = 011 on the next cycle; 101 on the following read.
REQ-036 In IDLE, clear_req together with write_enable (addr 1, sw 111) -> write dropped; busy for 4 cycles; ram_test = all 0 afterwards.
REQ-037 rst pulse on the 2nd CLEAR cycle -> clr_ptr restarts at 0; busy stays 1 for 4 more cycles after release; writes during busy do not change ram_test.
REQ-038 DATA_W = 8, ADDR_W = 4: write 0xA5 to address 15 -> ram_test[15] = 0xA5 at once; led = 0xA5 one cycle after reading address 15; clear takes 16 cycles.
